latch_rd_sampler: RTL and testbench
===================================

Name: latch_rd_sampler

Overview:
- Synchronous reader for a level-sensitive D-latch storage element.
- Watches the latch enable, which comes from another timing domain, and waits for the latch to close (enable low) and settle.
- Then captures the latch Q into a clocked register and presents it on a valid/ready output.
- Sits between latch-based temporary storage and downstream clocked logic.

Parameters:
- DATA_W, 8, width of latch data and output data.
- SYNC_STAGES, 2, flops in the enable synchronizer; legal range 2..4.
- STABLE_CYC, 2, cycles the synced enable must stay low before capture; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- latch_en_i  in  1  enable of the upstream latch; asynchronous to clk.
- latch_q_i  in  DATA_W  Q of the upstream latch; only stable while the latch is closed.
- out_valid  out  1  captured word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  captured latch value.
- busy  out  1  high in SETTLE or HOLD.
- overrun  out  1  one-cycle pulse: a new latch close was missed because HOLD was not yet accepted.

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers:
  - sync chain = 0, en_prev = 0, state = IDLE, cnt = 0;
  - out_valid = 0, out_data = 0, busy = 0, overrun = 0.
- Synchronizer: latch_en_i passes through SYNC_STAGES flops, giving en_s. en_prev is en_s delayed one cycle.
- Close event: fall = en_prev & ~en_s. This is combinational and evaluated every cycle.
- FSM state IDLE:
  - on fall, go to SETTLE with cnt = 0;
  - otherwise stay.
- FSM state SETTLE:
  - If en_s = 1, the latch reopened: abort, go to IDLE, no capture, no overrun.
  - Else if cnt == STABLE_CYC-1: out_data <= latch_q_i, go to HOLD.
  - Else cnt <= cnt+1.
- FSM state HOLD:
  - out_valid = 1; out_data is held constant.
  - out_ready = 1 completes the transfer. Next state is IDLE, or SETTLE with cnt = 0 if fall occurs in the same cycle. No overrun in that case.
  - fall while out_ready = 0: overrun pulses for 1 cycle, the new close is dropped, and the FSM stays in HOLD.
- Latency: out_valid rises SYNC_STAGES+STABLE_CYC+1 clk edges after the first edge that samples latch_en_i low. With default parameters this is 5.
- Throughput: at most one word per latch close. Back-to-back closes need at least STABLE_CYC+2 cycles each when out_ready is tied high.
- latch_q_i is sampled only on the capture cycle; its value at all other times is ignored.
- out_valid must not drop without out_ready, and out_data must not change while out_valid is high.
- An enable pulse shorter than one clk period may be missed entirely. This is legal, and no overrun is reported.
- Reset mid-operation: a pending word is discarded. out_valid drops immediately (asynchronously).

Optional Feature:
- Macro: LATCH_RD_OVR_CNT_EN.
- Defined:
  - adds output port ovr_cnt [7:0], a saturating count of overrun pulses;
  - saturates at 255 and holds;
  - reset value 0.
- Undefined:
  - port and counter are absent;
  - overrun pulse behaviour is unchanged.

Decomposition:
- Package latch_rd_pkg:
  - typedef enum for IDLE, SETTLE, HOLD;
  - localparam defaults for DATA_W, SYNC_STAGES, STABLE_CYC;
  - overrun counter width constant (8).
- Sub-module bit_sync: parameterised N-stage single-bit synchronizer with async active-low reset to 0. It is used for latch_en_i.
- FSM, counter and capture register live in latch_rd_sampler.

Test Plan:
- Basic capture:
  - stimulus: latch_q_i = 8'hA5, latch_en_i high 3 cycles then low, out_ready = 1;
  - response: out_valid for 1 cycle exactly 5 edges after the low sample, with out_data = 8'hA5.
- Backpressure:
  - stimulus: capture 8'h3C with out_ready = 0 for 10 cycles;
  - response: out_valid and out_data = 8'h3C stay stable all 10 cycles; one accept when out_ready goes to 1; then IDLE.
- Abort:
  - stimulus: latch_en_i low for 1 synced cycle, then high again before STABLE_CYC elapses;
  - response: no out_valid, busy returns to 0, overrun = 0.
- Overrun:
  - stimulus: hold 8'h11 unaccepted, then a second close with latch_q_i = 8'h22;
  - response: overrun pulses once; out_data stays 8'h11; 8'h22 is never output; ovr_cnt = 1 when the macro is defined.
- Simultaneous events:
  - stimulus: out_ready = 1 in the same cycle a new fall is detected in HOLD;
  - response: first word accepted, no overrun, second word is output STABLE_CYC+1 cycles later.
- Reset mid-HOLD:
  - stimulus: assert rst_n = 0 asynchronously between clk edges while out_valid = 1;
  - response: out_valid, out_data, busy, overrun go to 0 immediately; after release the block sits in IDLE.

Source files
------------

// File: rtl/latch_rd_pkg.sv
// latch_rd_pkg: shared types and defaults for the latch read sampler.
//   state_t        : sampler FSM states
//   DEF_*          : default parameter values for latch_rd_sampler
//   OVR_CNT_W      : width of the optional overrun counter
//   CNT_W          : width of the settle counter (covers STABLE_CYC up to 15)
package latch_rd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CYC  = 2;

    localparam int OVR_CNT_W = 8;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-stage single-bit synchronizer, async active-low reset to 0.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input bit
//   q     out synchronized bit (N clk edges of latency)
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/latch_rd_sampler.sv
// latch_rd_sampler: clocked reader for a level-sensitive D-latch.
// Waits for the (asynchronous) latch enable to close and stay closed for
// STABLE_CYC synced cycles, then captures latch Q and offers it on a
// valid/ready port.
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   latch_en_i in  upstream latch enable, asynchronous to clk
//   latch_q_i  in  upstream latch Q, stable only while latch closed
//   out_valid  out captured word available
//   out_ready  in  downstream accepts the word
//   out_data   out captured word, constant while out_valid
//   busy       out high in SETTLE or HOLD
//   overrun    out one-cycle pulse: a close was dropped while holding
//   ovr_cnt    out saturating overrun count (only with LATCH_RD_OVR_CNT_EN)
// Optional feature macro: LATCH_RD_OVR_CNT_EN
module latch_rd_sampler
    import latch_rd_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,  // 2..4
    parameter int STABLE_CYC  = DEF_STABLE_CYC    // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              latch_en_i,
    input  logic [DATA_W-1:0] latch_q_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
`ifdef LATCH_RD_OVR_CNT_EN
    output logic              overrun,
    output logic [OVR_CNT_W-1:0] ovr_cnt
`else
    output logic              overrun
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             en_s;
    logic             en_prev;
    logic             fall;

    bit_sync #(.N(SYNC_STAGES)) u_en_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (latch_en_i),
        .q    (en_s)
    );

    // Latch just closed (synced enable 1 -> 0).
    assign fall = en_prev & ~en_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev   <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef LATCH_RD_OVR_CNT_EN
            ovr_cnt   <= '0;
`endif
        end else begin
            en_prev <= en_s;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Reopened before settling: Q is not trustworthy, drop it.
                    if (en_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        out_data  <= latch_q_i;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // A close coinciding with the accept is not lost.
                        if (fall) begin
                            state <= SETTLE;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (fall) begin
                        overrun <= 1'b1;
`ifdef LATCH_RD_OVR_CNT_EN
                        if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_rd_sampler.sv
// tb_latch_rd_sampler: directed stimulus with a scoreboard queue; a monitor
// process pops and compares on each accepted output word.
module tb_latch_rd_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       latch_en_i = 1'b0;
    logic [7:0] latch_q_i = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic       overrun;
`ifdef LATCH_RD_OVR_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    latch_rd_sampler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch_en_i(latch_en_i),
        .latch_q_i (latch_q_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
`ifdef LATCH_RD_OVR_CNT_EN
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
`else
        .overrun   (overrun)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Open the latch for 3 cycles with new data, then close it.
    task automatic close_latch(input logic [7:0] d, input bit push);
        latch_q_i  = d;
        latch_en_i = 1'b1;
        tick(3);
        latch_en_i = 1'b0;
        if (push) exp_q.push_back(d);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (out_valid) break;
            tick(1);
        end
        if (i == bound) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor: compares accepted words and enforces the hold rules.
    logic       prev_valid = 1'b0;
    logic       prev_acc = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_valid && !prev_acc) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("accept_data", {24'd0, out_data}, {24'd0, e});
                end
            end
            prev_valid = out_valid;
            prev_acc   = out_valid && out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, vcnt, ovr, saw_busy;
        bit stable;

        // Reset state
        tick(2);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef LATCH_RD_OVR_CNT_EN
        chk("rst_ovr_cnt", {24'd0, ovr_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        tick(2);

        // Basic capture: valid on the 5th edge counting the sampling edge
        out_ready = 1'b1;
        close_latch(8'hA5, 1);
        first = 0; vcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (out_valid && first == 0) first = k;
            if (out_valid) vcnt++;
        end
        chk("basic_latency", first, 5);
        chk("basic_valid_cycles", vcnt, 1);
        chk("basic_idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        close_latch(8'h3C, 1);
        wait_valid("bp", 20);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!out_valid || out_data !== 8'h3C || !busy) stable = 1'b0;
            tick(1);
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        tick(1);
        chk("bp_accept_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_accept_busy", {31'd0, busy}, 32'd0);
        tick(2);

        // Abort: enable low for a single sampled cycle
        latch_en_i = 1'b1;
        tick(3);
        latch_en_i = 1'b0;
        tick(1);
        latch_en_i = 1'b1;
        vcnt = 0; ovr = 0; saw_busy = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (out_valid) vcnt++;
            if (overrun) ovr++;
            if (busy) saw_busy = 1;
        end
        chk("abort_no_valid", vcnt, 0);
        chk("abort_no_overrun", ovr, 0);
        chk("abort_saw_busy", saw_busy, 1);
        chk("abort_busy_low", {31'd0, busy}, 32'd0);
        latch_en_i = 1'b0;
        tick(4);

        // Overrun
        out_ready = 1'b0;
        close_latch(8'h11, 1);
        wait_valid("ovr", 20);
        close_latch(8'h22, 0);
        ovr = 0; stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (overrun) ovr++;
            if (!out_valid || out_data !== 8'h11) stable = 1'b0;
        end
        chk("ovr_pulses", ovr, 1);
        chk("ovr_data_kept", {31'd0, stable}, 32'd1);
`ifdef LATCH_RD_OVR_CNT_EN
        chk("ovr_cnt", {24'd0, ovr_cnt}, 32'd1);
`endif
        out_ready = 1'b1;
        tick(1);
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) vcnt++;
            tick(1);
        end
        chk("ovr_dropped_word", vcnt, 0);

        // Simultaneous accept and new close
        out_ready = 1'b0;
        close_latch(8'h55, 1);
        wait_valid("sim", 20);
        close_latch(8'h66, 1);
        tick(2);             // fall is now visible in HOLD
        out_ready = 1'b1;
        first = 0; ovr = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (overrun) ovr++;
            if (out_valid && first == 0) first = k;
        end
        chk("sim_second_latency", first, 3);
        chk("sim_no_overrun", ovr, 0);
        tick(2);

        // Reset mid-HOLD
        out_ready = 1'b0;
        close_latch(8'h77, 1);
        wait_valid("rst", 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
`ifdef LATCH_RD_OVR_CNT_EN
        chk("arst_ovr_cnt", {24'd0, ovr_cnt}, 32'd0);
`endif
        void'(exp_q.pop_back());
        tick(2);
        rst_n = 1'b1;
        vcnt = 0; saw_busy = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (out_valid) vcnt++;
            if (busy) saw_busy = 1;
        end
        chk("post_rst_idle_valid", vcnt, 0);
        chk("post_rst_idle_busy", saw_busy, 0);

        // Normal operation after reset
        out_ready = 1'b1;
        close_latch(8'h99, 1);
        wait_valid("final", 20);
        tick(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
